// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory and
// holds the fetched word until decode consumes it, then selects the next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        decode_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] sign_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic        addr_err,
  output logic [31:0] retired_count
);

  typedef enum logic {
    StFetch = 1'b0,
    StHold  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] next_pc;

  assign pc_plus4_w = pc_q + 32'd4;

  // Redirect priority: jr over jump over taken branch over sequential.
  always_comb begin
    next_pc = pc_plus4_w;
    if (jr) begin
      next_pc = {jr_addr[31:2], 2'b00};
    end else if (jump) begin
      next_pc = {pc_plus4_w[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4_w + (sign_imm << 2);
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    retired_d  = retired_q;
    addr_err_d = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        // An ack arriving here is a protocol violation and is dropped.
        if (decode_ready) begin
          state_d    = StFetch;
          pc_d       = next_pc;
          retired_d  = retired_q + 32'd1;
          addr_err_d = jr & (|jr_addr[1:0]);
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      instr_q    <= 32'h0;
      retired_q  <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      retired_q  <= retired_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign imem_req      = (state_q == StFetch);
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign instr_valid   = (state_q == StHold);
  assign pc            = pc_q;
  assign pc_plus4      = pc_plus4_w;
  assign addr_err      = addr_err_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural instruction memory with a
// programmable ack delay, and a queue of expected fetch addresses.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic        instr_valid;
  logic        decode_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken = 1'b0;
  logic [31:0] sign_imm = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = 26'h0;
  logic        jr = 1'b0;
  logic [31:0] jr_addr = 32'h0;
  logic        addr_err;
  logic [31:0] retired_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_delay = 0;
  int          wait_cnt = 0;
  logic        ack_force = 1'b0;
  logic        sb_on = 1'b1;
  logic        req_prev = 1'b0;
  logic        rst_prev = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_retired;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .sign_imm     (sign_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .addr_err     (addr_err),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  assign imem_ack   = ack_force | ((imem_req === 1'b1) && (wait_cnt >= mem_delay));
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (imem_req === 1'b1 && imem_ack === 1'b0) wait_cnt = wait_cnt + 1;
    else wait_cnt = 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each new fetch must go to the address predicted when the redirect was driven.
  always @(negedge clk) begin
    if (sb_on && rst === 1'b0 && imem_req === 1'b1 && (!req_prev || rst_prev)) begin
      if (exp_q.size() == 0) check("unexpected_fetch", imem_addr, 32'hXXXX_XXXX);
      else check("fetch_addr", imem_addr, exp_q.pop_front());
    end
    req_prev = (imem_req === 1'b1);
    rst_prev = rst;
  end

  task automatic wait_valid();
    int n = 0;
    while (instr_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (instr_valid !== 1'b1) check("valid_timeout", {31'h0, instr_valid}, 32'h1);
  endtask

  task automatic consume(input logic br, input logic [31:0] imm, input logic j,
                         input logic [25:0] idx, input logic jrr, input logic [31:0] jaddr);
    logic [31:0] pp4, nxt;
    logic        exp_err;
    wait_valid();
    pp4 = m_pc + 32'd4;
    check("hold_instr", instr, mem_word(m_pc));
    check("hold_pc", pc, m_pc);
    check("hold_pc_plus4", pc_plus4, pp4);
    check("hold_retired", retired_count, m_retired);
    if (jrr) nxt = {jaddr[31:2], 2'b00};
    else if (j) nxt = {pp4[31:28], idx, 2'b00};
    else if (br) nxt = pp4 + (imm << 2);
    else nxt = pp4;
    exp_err = jrr && (jaddr[1:0] != 2'b00);
    branch_taken = br; sign_imm = imm; jump = j; jump_index = idx; jr = jrr; jr_addr = jaddr;
    decode_ready = 1'b1;
    exp_q.push_back(nxt);
    @(negedge clk);
    decode_ready = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    m_pc = nxt;
    m_retired = m_retired + 32'd1;
    check("addr_err_pulse", {31'h0, addr_err}, {31'h0, exp_err});
    check("valid_after_consume", {31'h0, instr_valid}, 32'h0);
    check("retired_inc", retired_count, m_retired);
    @(negedge clk);
    check("addr_err_clear", {31'h0, addr_err}, 32'h0);
  endtask

  initial begin
    int n;
    // Test 1: zero-wait memory, decode always ready.
    m_pc = 32'h0; m_retired = 32'h0;
    decode_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_retired", retired_count, 32'h0);
    check("rst_addr_err", {31'h0, addr_err}, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t1_valid", {31'h0, instr_valid}, (k % 2 == 1) ? 32'h1 : 32'h0);
      check("t1_req", {31'h0, imem_req}, (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    @(posedge clk);
    #1 decode_ready = 1'b0;
    check("t1_retired", retired_count, 32'd4);
    m_pc = 32'h10; m_retired = 32'd4;

    // Test 2: 3-cycle ack delay, then a 5-cycle decode stall.
    mem_delay = 3;
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      check("t2_addr_stable", imem_addr, m_pc);
      check("t2_req", {31'h0, imem_req}, 32'h1);
      @(posedge clk);
      #1 n++;
    end
    check("t2_fetch_cycles", n, 32'd4);
    repeat (5) begin
      @(negedge clk);
      check("t2_stall_instr", instr, mem_word(m_pc));
      check("t2_stall_pc", pc, m_pc);
      check("t2_stall_req", {31'h0, imem_req}, 32'h0);
      check("t2_stall_retired", retired_count, m_retired);
    end
    consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    mem_delay = 1;

    // Test 3: branches, backwards and forwards, from pc 0x100.
    consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0100);
    consume(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0);
    check("t3_back", m_pc, 32'h0000_00FC);
    consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0100);
    consume(1'b1, 32'h0000_0003, 1'b0, 26'h0, 1'b0, 32'h0);
    check("t3_fwd", pc, 32'h0000_0110);
    mem_delay = 0;

    // Test 4: jump beats branch; jr beats jump and flags misalignment.
    consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h4000_0010);
    consume(1'b1, 32'h0000_0010, 1'b1, 26'h000_0040, 1'b0, 32'h0);
    wait_valid();
    check("t4_jump", pc, 32'h4000_0100);
    consume(1'b0, 32'h0, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h0000_2003);
    wait_valid();
    check("t4_jr", pc, 32'h0000_2000);

    // Test 6: PC and retired counter wrap.
    consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
    wait_valid();
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("t6_pc_wrap", m_pc, 32'h0);
    check("t6_retired_wrap", retired_count, 32'h0);

    // Test 5: reset mid-fetch with a coincident ack.
    wait_valid();
    mem_delay = 100;
    consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0800);
    sb_on = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1; ack_force = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; ack_force = 1'b0;
    check("t5_valid", {31'h0, instr_valid}, 32'h0);
    check("t5_pc", pc, 32'h0);
    check("t5_retired", retired_count, 32'h0);
    check("t5_req", {31'h0, imem_req}, 32'h1);
    check("t5_addr", imem_addr, 32'h0);
    check("t5_instr", instr, 32'h0);
    mem_delay = 0;
    exp_q.delete();
    m_pc = 32'h0; m_retired = 32'h0;
    @(negedge clk);
    wait_valid();
    sb_on = 1'b1;
    consume(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    wait_valid();
    check("t5_resume_pc", pc, 32'h4);
    check("sb_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 32-bit MIPS-subset core.
- Owns the PC and handshakes with instruction memory.
- Holds the fetched word for decode. Decode feeds bits [15:0] to the immediate extender and bits [31:26] to the opcode decoder.
- Computes the next PC from the sign-extended immediate (branches), the 26-bit jump field, or a register (jr), so it both feeds and consumes the immediate path.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset; must be word-aligned.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch byte address (always word-aligned)
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- imem_ack  in  1  memory completion strobe, one cycle per request
- instr  out  32  held instruction for decode
- instr_valid  out  1  instr/pc/pc_plus4 are valid
- decode_ready  in  1  decode/execute consumes the instruction this cycle
- pc  out  32  address of the held instruction
- pc_plus4  out  32  pc + 4, mod 2^32
- branch_taken  in  1  conditional branch resolved taken (sampled on consume)
- sign_imm  in  32  sign-extended branch offset in words
- jump  in  1  j/jal taken (sampled on consume)
- jump_index  in  26  instr[25:0] jump field
- jr  in  1  jump-register taken (sampled on consume)
- jr_addr  in  32  register jump target
- addr_err  out  1  one-cycle pulse: jr_addr was misaligned
- retired_count  out  32  number of consumed instructions

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-fetch):
  - state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, addr_err=0, retired_count=0.
  - An imem_ack in the reset cycle is ignored.
  - imem_req=1 with imem_addr=RESET_PC from the first cycle after reset.
- State FETCH:
  - imem_req=1 and imem_addr=pc, stable until ack; instr_valid=0.
  - imem_ack may arrive the same cycle as the request or any later cycle.
  - On imem_ack: instr<=imem_rdata, state<=HOLD.
  - decode_ready and redirect inputs are ignored in FETCH.
- State HOLD:
  - imem_req=0, instr_valid=1; instr and pc held stable while decode_ready=0, for any number of cycles.
  - Consume = instr_valid & decode_ready. On consume:
    - state<=FETCH.
    - retired_count<=retired_count+1 (wraps 2^32-1 -> 0).
    - pc<=next_pc.
- next_pc priority, evaluated only on consume, exactly one source used:
  1. jr: jr_addr with bits[1:0] forced to 00; addr_err=1 in the following cycle if jr_addr[1:0]!=0.
  2. jump: {pc_plus4[31:28], jump_index, 2'b00}.
  3. branch_taken: pc_plus4 + (sign_imm<<2), 32-bit wrap, overflow ignored.
  4. otherwise: pc_plus4.
- imem_ack while in HOLD is a protocol violation; it is ignored and must not change state.
- Throughput: at most one instruction every 2 cycles with a zero-wait memory (ack in request cycle -> instr_valid next cycle -> consume -> new request next cycle).
- PC wrap: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000.
- All outputs registered except imem_addr (=pc), pc_plus4 (=pc+4) and imem_req (decoded from state).

Test Plan:
1. Reset, RESET_PC=0, zero-wait memory returning addr-based words, decode_ready=1 always -> imem_addr sequence 0,4,8,C; instr_valid high every 2nd cycle; retired_count=4 after 8 cycles.
2. Memory with 3-cycle ack delay and decode_ready held low 5 cycles in HOLD -> imem_addr stable through wait; instr/pc unchanged during stall; exactly one increment of retired_count.
3. pc=0x0000_0100, branch_taken=1, sign_imm=0xFFFF_FFFE on consume -> next imem_addr=0x0000_00FC. Repeat with sign_imm=0x0000_0003 -> 0x0000_0110.
4. pc=0x4000_0010, jump=1, jump_index=26'h0000_040, branch_taken=1 simultaneously -> next pc=0x4000_0100 (jump wins). Then jr=1, jump=1, jr_addr=0x0000_2003 -> next pc=0x0000_2000, addr_err pulses exactly one cycle.
5. Assert rst while in FETCH with imem_ack arriving in the same cycle -> instr_valid=0, pc=RESET_PC, retired_count=0, imem_req=1 next cycle, ack data not captured.
6. pc=0xFFFF_FFFC sequential consume -> imem_addr=0x0000_0000; retired_count preset via 2^32-1 consumes (or force) wraps to 0.
